pc_redirect_sequencer: RTL
==========================

# pc_redirect_sequencer

Program-counter sequencer for the 16-bit core's fetch stage. Holds the PC, advances it sequentially, and applies branch/jump redirects using a `sign_extend_shifter` instance to form targets. Buffers a redirect that arrives during a stall, emits a one-cycle pipeline flush, and supports a terminal halt.

## Interface
- PC_WIDTH, 16, PC and target width
- OFFSET_WIDTH, 12, jump offset width (full offset field)
- BR_OFFSET_WIDTH, 8, branch offset width (low bits of offset field)
- SHIFT_AMOUNT, 1, left shift applied to the extended offset
- PC_INC, 2, sequential increment
- RESET_PC, 16'h0000, PC value after reset
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold PC this cycle
- halt_req  in  1  halt instruction reached
- redir_valid  in  1  branch/jump resolved this cycle
- redir_jump  in  1  1 = jump (OFFSET_WIDTH offset, always taken); 0 = branch (BR_OFFSET_WIDTH offset)
- redir_taken  in  1  branch condition true; ignored when redir_jump=1
- redir_base  in  PC_WIDTH  base address the offset is added to
- redir_offset  in  OFFSET_WIDTH  raw offset field
- pc  out  PC_WIDTH  current fetch address
- pc_valid  out  1  pc is a live fetch address
- flush  out  1  squash younger in-flight instructions
- halted  out  1  core halted
- redir_count  out  16  redirects applied (REDIR_COUNT_EN only)

## Operation
- target = (redir_base + sext_shift(redir_offset, redir_jump)) mod 2^PC_WIDTH; sext_shift from `sign_extend_shifter` with jump select.
- redirect = redir_valid & (redir_jump | redir_taken). Not-taken branch behaves as no redirect.
- States: RUN, FLUSH, PEND, HALT. Reset → RUN.
- RUN, priority order:
  - redirect & !stall: pc ← target; → FLUSH.
  - redirect & stall: pend_pc ← target; pc held; → PEND.
  - halt_req: pc held; → HALT. Redirect beats halt.
  - stall: pc held.
  - else: pc ← pc + PC_INC (wraps mod 2^PC_WIDTH).
- FLUSH: flush=1 for exactly this cycle; redir_* and halt_req ignored (squashed sources). pc advances or holds per stall. Always → RUN.
- PEND: pc held; redir_* and halt_req ignored. When stall=0: pc ← pend_pc, → FLUSH.
- HALT: pc frozen, all inputs ignored; exit only via rst.
- pc_valid = 1 in RUN/FLUSH, 0 in PEND/HALT. halted = 1 only in HALT.
- rst mid-operation (any state, including PEND) discards pend_pc and returns to RUN with pc=RESET_PC.

## Timing
- Reset values: pc=RESET_PC, pc_valid=1, flush=0, halted=0, redir_count=0.
- Redirect sampled at edge N (no stall): pc=target after edge N; flush=1 during cycle N+1 only.
- Stalled redirect: pc=pend_pc after the first edge with stall=0; flush the following cycle.
- halted rises the cycle after halt_req is sampled in RUN.
- All outputs registered or decoded from state only; no combinational input→output path.

## Configuration
- REDIR_COUNT_EN defined: redir_count port present; increments by 1 on every edge where pc loads a target (RUN direct or PEND release); saturates at 16'hFFFF; cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package: state encoding typedef (RUN, FLUSH, PEND, HALT), PC_INC and RESET_PC defaults.
- One sub-module: `sign_extend_shifter`, parameterised OFFSET_WIDTH / BR_OFFSET_WIDTH / PC_WIDTH / SHIFT_AMOUNT, jump input driven by redir_jump.

## Test plan
- rst then 3 free-running cycles → pc 0x0000, 0x0002, 0x0004, 0x0006; pc_valid=1, flush=0.
- Branch taken, base 0x0020, offset 12'h0FC → pc=0x0018 next cycle; flush=1 one cycle; redir_valid in FLUSH ignored.
- Jump, base 0x0100, offset 12'h7FF → pc=0x10FE; not-taken branch same cycle in another run → pc+2.
- Redirect with stall=1 held 3 cycles → PEND, pc held, pc_valid=0; stall drops → pc=target, flush next cycle; rst during PEND → pc=0x0000, RUN.
- pc=0xFFFE, no stall → pc=0x0000; jump base 0xFFF0, offset 12'h010 → pc=0x0010 (wrap).
- redirect and halt_req together → redirect taken, not halted; halt_req alone → halted=1, pc frozen for 10 cycles despite redirects; with REDIR_COUNT_EN, redir_count equals applied redirects.

Source files
------------

// File: rtl/pc_redirect_sequencer_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer.
package pc_redirect_sequencer_pkg;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FLUSH = 2'd1,
      S_PEND  = 2'd2,
      S_HALT  = 2'd3
   } seq_state_e;

   localparam int          PC_INC_DEF   = 2;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;

endpackage

// File: rtl/pc_redirect_sequencer_if.sv
// Fetch-side bundle between the branch resolver and the PC sequencer.
interface pc_redirect_sequencer_if #(
   parameter int PC_WIDTH     = 16,
   parameter int OFFSET_WIDTH = 12
);
   logic                    stall;
   logic                    halt_req;
   logic                    redir_valid;
   logic                    redir_jump;
   logic                    redir_taken;
   logic [PC_WIDTH-1:0]     redir_base;
   logic [OFFSET_WIDTH-1:0] redir_offset;
   logic [PC_WIDTH-1:0]     pc;
   logic                    pc_valid;
   logic                    flush;
   logic                    halted;
`ifdef REDIR_COUNT_EN
   logic [15:0]             redir_count;
`endif

   modport master (
`ifdef REDIR_COUNT_EN
      input  redir_count,
`endif
      output stall, halt_req, redir_valid, redir_jump, redir_taken,
      output redir_base, redir_offset,
      input  pc, pc_valid, flush, halted
   );

   modport slave (
`ifdef REDIR_COUNT_EN
      output redir_count,
`endif
      input  stall, halt_req, redir_valid, redir_jump, redir_taken,
      input  redir_base, redir_offset,
      output pc, pc_valid, flush, halted
   );
endinterface

// File: rtl/pc_redirect_sequencer_sign_extend_shifter.sv
// Sign-extends a jump (full field) or branch (low bits) offset and scales it.
// Purely combinational; no state, no backpressure.
module sign_extend_shifter #(
   parameter int OFFSET_WIDTH    = 12,
   parameter int BR_OFFSET_WIDTH = 8,
   parameter int PC_WIDTH        = 16,
   parameter int SHIFT_AMOUNT    = 1
) (
   input  logic [OFFSET_WIDTH-1:0] offset_i,
   input  logic                    jump_i,
   output logic [PC_WIDTH-1:0]     ext_o
);
   logic [PC_WIDTH-1:0] jmp_ext;
   logic [PC_WIDTH-1:0] br_ext;

   assign jmp_ext = {{(PC_WIDTH-OFFSET_WIDTH){offset_i[OFFSET_WIDTH-1]}}, offset_i};
   assign br_ext  = {{(PC_WIDTH-BR_OFFSET_WIDTH){offset_i[BR_OFFSET_WIDTH-1]}},
                     offset_i[BR_OFFSET_WIDTH-1:0]};
   assign ext_o   = (jump_i ? jmp_ext : br_ext) << SHIFT_AMOUNT;
endmodule

// File: rtl/pc_redirect_sequencer.sv
// Fetch PC sequencer: step/redirect/stall-buffered redirect/halt; 1-cycle redirect latency, flush after.
// Optional redirect counter behind REDIR_COUNT_EN. All outputs registered.
module pc_redirect_sequencer
   import pc_redirect_sequencer_pkg::*;
#(
   parameter int                  PC_WIDTH        = 16,
   parameter int                  OFFSET_WIDTH    = 12,
   parameter int                  BR_OFFSET_WIDTH = 8,
   parameter int                  SHIFT_AMOUNT    = 1,
   parameter int                  PC_INC          = PC_INC_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_PC        = PC_WIDTH'(RESET_PC_DEF)
) (
   input logic clk,
   input logic rst,
   pc_redirect_sequencer_if.slave bus
);
   seq_state_e          state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pend_pc_q;
   logic                pc_valid_q;
   logic                flush_q;
   logic                halted_q;
   logic [PC_WIDTH-1:0] offset_ext;
   logic [PC_WIDTH-1:0] target;
   logic [PC_WIDTH-1:0] pc_step;
   logic                redirect;

   sign_extend_shifter #(
      .OFFSET_WIDTH    (OFFSET_WIDTH),
      .BR_OFFSET_WIDTH (BR_OFFSET_WIDTH),
      .PC_WIDTH        (PC_WIDTH),
      .SHIFT_AMOUNT    (SHIFT_AMOUNT)
   ) u_sext (
      .offset_i (bus.redir_offset),
      .jump_i   (bus.redir_jump),
      .ext_o    (offset_ext)
   );

   assign target   = bus.redir_base + offset_ext;
   assign pc_step  = pc_q + PC_WIDTH'(PC_INC);
   assign redirect = bus.redir_valid & (bus.redir_jump | bus.redir_taken);

`ifdef REDIR_COUNT_EN
   logic [15:0] count_q;
   logic [15:0] count_d;
   logic        load_tgt;

   // Counts every edge where pc is loaded from a target, saturating.
   assign load_tgt = ((state_q == S_RUN) && redirect && !bus.stall) ||
                     ((state_q == S_PEND) && !bus.stall);
   assign count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           count_q <= '0;
      else if (load_tgt) count_q <= count_d;
   end

   assign bus.redir_count = count_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_RUN;
         pc_q       <= RESET_PC;
         pend_pc_q  <= '0;
         pc_valid_q <= 1'b1;
         flush_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         flush_q <= 1'b0;
         case (state_q)
            S_RUN: begin
               // Redirect outranks halt: a halt in the wrong path must not stop the core.
               if (redirect && !bus.stall) begin
                  pc_q    <= target;
                  flush_q <= 1'b1;
                  state_q <= S_FLUSH;
               end else if (redirect) begin
                  pend_pc_q  <= target;
                  pc_valid_q <= 1'b0;
                  state_q    <= S_PEND;
               end else if (bus.halt_req) begin
                  pc_valid_q <= 1'b0;
                  halted_q   <= 1'b1;
                  state_q    <= S_HALT;
               end else if (!bus.stall) begin
                  pc_q <= pc_step;
               end
            end
            S_FLUSH: begin
               if (!bus.stall) pc_q <= pc_step;
               state_q <= S_RUN;
            end
            S_PEND: begin
               if (!bus.stall) begin
                  pc_q       <= pend_pc_q;
                  pc_valid_q <= 1'b1;
                  flush_q    <= 1'b1;
                  state_q    <= S_FLUSH;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.pc       = pc_q;
   assign bus.pc_valid = pc_valid_q;
   assign bus.flush    = flush_q;
   assign bus.halted   = halted_q;
endmodule
